// File: rtl/mem_responder_pkg.sv
// Shared definitions for the mem_responder block.
//   - Default geometry/timing parameters.
//   - FSM state encoding (IDLE=0, BUSY=1, RESP=2).
//   - Byte-lane merge helper used by the RAM and by the store trace.
package mem_responder_pkg;

  localparam int DEFAULT_DEPTH_WORDS = 1024;
  localparam int DEFAULT_LATENCY     = 2;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_BUSY = 2'd1,
    ST_RESP = 2'd2
  } state_t;

  // Replace the lanes of old_word selected by be with the matching lanes of new_word.
  function automatic logic [31:0] merge_bytes(
    input logic [31:0] old_word,
    input logic [31:0] new_word,
    input logic [3:0]  be
  );
    logic [31:0] merged;
    merged = old_word;
    for (int i = 0; i < 4; i++) begin
      if (be[i]) begin
        merged[8*i +: 8] = new_word[8*i +: 8];
      end
    end
    return merged;
  endfunction

endpackage

// File: rtl/mem_responder_mem_array.sv
// mem_array: byte-enabled word RAM, synchronous write, asynchronous read,
// synchronous clear of every word on reset.
// Ports:
//   clk      - clock
//   reset    - synchronous active-high clear (wins over any write)
//   i_we     - write strobe
//   i_index  - word index for both read and write
//   i_wdata  - write data, byte lanes aligned to the word
//   i_be     - byte enables, bit i selects i_wdata[8i+7:8i]
//   o_rdata  - combinational read of the word at i_index
module mem_array
  import mem_responder_pkg::*;
#(
  parameter int DEPTH_WORDS = DEFAULT_DEPTH_WORDS,
  parameter int AW          = $clog2(DEPTH_WORDS)
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          i_we,
  input  logic [AW-1:0] i_index,
  input  logic [31:0]   i_wdata,
  input  logic [3:0]    i_be,
  output logic [31:0]   o_rdata
);

  logic [31:0] w_words [DEPTH_WORDS];

  // Each word is its own register so that the whole array can be cleared in
  // one cycle; the read side is a plain mux over the words.
  generate
    for (genvar gi = 0; gi < DEPTH_WORDS; gi++) begin : g_word
      logic [31:0] r_word;

      always_ff @(posedge clk) begin
        if (reset) begin
          r_word <= '0;
        end else if (i_we && (i_index == AW'(gi))) begin
          r_word <= merge_bytes(r_word, i_wdata, i_be);
        end
      end

      assign w_words[gi] = r_word;
    end
  endgenerate

  assign o_rdata = w_words[i_index];

endmodule

// File: rtl/mem_responder.sv
// mem_responder: single-outstanding memory responder with fixed access latency.
// A request is accepted in IDLE, waits LATENCY edges in BUSY, performs the
// access on the last BUSY edge and presents the response in RESP until the
// initiator consumes it.
// Ports:
//   clk, reset                     - clock, synchronous active-high reset
//   req_valid/req_ready            - request handshake (ready only in IDLE)
//   req_write, req_addr, req_wdata,
//   req_be, req_pc                 - request payload (captured on acceptance)
//   resp_valid/resp_ready          - response handshake (valid only in RESP)
//   resp_rdata, resp_err           - load data / out-of-range flag
//   trace_valid, trace_pc,
//   trace_addr, trace_data         - store trace: high for the one cycle in which
//                                    an in-range store with be != 0 commits;
//                                    addr is the word-aligned byte address and
//                                    data is the merged word being written
module mem_responder
  import mem_responder_pkg::*;
#(
  parameter int DEPTH_WORDS = DEFAULT_DEPTH_WORDS,
  parameter int LATENCY     = DEFAULT_LATENCY
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic        req_write,
  input  logic [31:0] req_addr,
  input  logic [31:0] req_wdata,
  input  logic [3:0]  req_be,
  input  logic [31:0] req_pc,
  output logic        resp_valid,
  input  logic        resp_ready,
  output logic [31:0] resp_rdata,
  output logic        resp_err,
  output logic        trace_valid,
  output logic [31:0] trace_pc,
  output logic [31:0] trace_addr,
  output logic [31:0] trace_data
);

  localparam int AW = $clog2(DEPTH_WORDS);
  localparam int CW = $clog2(LATENCY + 1);
  localparam logic [CW-1:0] CNT_LOAD = CW'(LATENCY - 1);

  state_t        r_state;
  state_t        w_state_next;
  logic [CW-1:0] r_cnt;
  logic [CW-1:0] w_cnt_next;

  logic          r_write;
  logic [31:0]   r_addr;
  logic [31:0]   r_wdata;
  logic [3:0]    r_be;
  logic [31:0]   r_pc;
  logic [31:0]   r_rdata;
  logic          r_err;

  logic          w_accept;
  logic          w_access;
  logic          w_in_range;
  logic          w_mem_we;
  logic [31:0]   w_mem_rdata;

  // Everything at or above 4*DEPTH_WORDS bytes is out of range.
  assign w_in_range = ((r_addr >> (AW + 2)) == 32'd0);

  // Zero-lane stores are legal but change nothing, so they neither write nor trace.
  assign w_mem_we = w_access && r_write && w_in_range && (r_be != 4'b0000);

  // ---------------------------------------------------------------- FSM
  always_ff @(posedge clk) begin
    if (reset) begin
      r_state <= ST_IDLE;
      r_cnt   <= '0;
    end else begin
      r_state <= w_state_next;
      r_cnt   <= w_cnt_next;
    end
  end

  always_comb begin
    w_state_next = r_state;
    w_cnt_next   = r_cnt;
    w_accept     = 1'b0;
    w_access     = 1'b0;
    req_ready    = 1'b0;
    resp_valid   = 1'b0;
    case (r_state)
      ST_IDLE: begin
        req_ready = 1'b1;
        if (req_valid) begin
          w_accept     = 1'b1;
          w_cnt_next   = CNT_LOAD;
          w_state_next = ST_BUSY;
        end
      end
      ST_BUSY: begin
        if (r_cnt != '0) begin
          w_cnt_next = r_cnt - CW'(1);
        end else begin
          w_access     = 1'b1;
          w_state_next = ST_RESP;
        end
      end
      ST_RESP: begin
        resp_valid = 1'b1;
        if (resp_ready) begin
          w_state_next = ST_IDLE;
        end
      end
      default: begin
        w_state_next = ST_IDLE;
      end
    endcase
  end

  // ------------------------------------------------------ request / response
  always_ff @(posedge clk) begin
    if (reset) begin
      r_write <= 1'b0;
      r_addr  <= '0;
      r_wdata <= '0;
      r_be    <= '0;
      r_pc    <= '0;
      r_rdata <= '0;
      r_err   <= 1'b0;
    end else begin
      if (w_accept) begin
        r_write <= req_write;
        r_addr  <= req_addr;
        r_wdata <= req_wdata;
        r_be    <= req_be;
        r_pc    <= req_pc;
      end
      // The response registers only change on the access edge, so they are
      // naturally stable for the whole RESP phase.
      if (w_access) begin
        r_rdata <= (!r_write && w_in_range) ? w_mem_rdata : 32'd0;
        r_err   <= !w_in_range;
      end
    end
  end

  assign resp_rdata = r_rdata;
  assign resp_err   = r_err;

  // ------------------------------------------------------------- storage
  mem_array #(
    .DEPTH_WORDS (DEPTH_WORDS),
    .AW          (AW)
  ) u_mem_array (
    .clk     (clk),
    .reset   (reset),
    .i_we    (w_mem_we),
    .i_index (r_addr[AW+1:2]),
    .i_wdata (r_wdata),
    .i_be    (r_be),
    .o_rdata (w_mem_rdata)
  );

  // --------------------------------------------------------------- trace
  // Suppressed while reset is high: an abandoned store must not be reported.
  assign trace_valid = w_mem_we && !reset;
  assign trace_pc    = r_pc;
  assign trace_addr  = {r_addr[31:2], 2'b00};
  assign trace_data  = merge_bytes(w_mem_rdata, r_wdata, r_be);

endmodule

// File: tb/tb_mem_responder.sv
module tb_mem_responder;

  localparam int DEPTH = 1024;

  logic        clk = 1'b0;
  logic        reset;
  logic        req_valid;
  logic        req_write;
  logic [31:0] req_addr;
  logic [31:0] req_wdata;
  logic [3:0]  req_be;
  logic [31:0] req_pc;
  logic        resp_ready;

  // DUT a: default build (LATENCY=2); DUT b: LATENCY=1 build, same stimulus.
  logic        a_req_ready, a_resp_valid, a_resp_err, a_trace_valid;
  logic [31:0] a_resp_rdata, a_trace_pc, a_trace_addr, a_trace_data;
  logic        b_req_ready, b_resp_valid, b_resp_err, b_trace_valid;
  logic [31:0] b_resp_rdata, b_trace_pc, b_trace_addr, b_trace_data;

  always #5 clk = ~clk;

  mem_responder #(.DEPTH_WORDS(DEPTH), .LATENCY(2)) u_dut_a (
    .clk(clk), .reset(reset),
    .req_valid(req_valid), .req_ready(a_req_ready), .req_write(req_write),
    .req_addr(req_addr), .req_wdata(req_wdata), .req_be(req_be), .req_pc(req_pc),
    .resp_valid(a_resp_valid), .resp_ready(resp_ready),
    .resp_rdata(a_resp_rdata), .resp_err(a_resp_err),
    .trace_valid(a_trace_valid), .trace_pc(a_trace_pc),
    .trace_addr(a_trace_addr), .trace_data(a_trace_data)
  );

  mem_responder #(.DEPTH_WORDS(DEPTH), .LATENCY(1)) u_dut_b (
    .clk(clk), .reset(reset),
    .req_valid(req_valid), .req_ready(b_req_ready), .req_write(req_write),
    .req_addr(req_addr), .req_wdata(req_wdata), .req_be(req_be), .req_pc(req_pc),
    .resp_valid(b_resp_valid), .resp_ready(resp_ready),
    .resp_rdata(b_resp_rdata), .resp_err(b_resp_err),
    .trace_valid(b_trace_valid), .trace_pc(b_trace_pc),
    .trace_addr(b_trace_addr), .trace_data(b_trace_data)
  );

  int checks = 0;
  int errors = 0;
  logic [31:0] model_mem [DEPTH];

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %08h expected %08h", tag, obs, exp);
    end
  endtask

  // Reference model: word array indexed by byte address / 4.
  task automatic model_access(input logic w, input logic [31:0] addr, input logic [31:0] wdata,
                              input logic [3:0] be, output logic [31:0] rd, output logic err,
                              output int ntr, output logic [31:0] tdata);
    int          idx;
    logic [31:0] word;
    rd = 32'd0; err = 1'b0; ntr = 0; tdata = 32'd0;
    if (addr >= 32'(4 * DEPTH)) begin
      err = 1'b1;
    end else begin
      idx  = int'(addr / 4);
      word = model_mem[idx];
      if (w) begin
        for (int b = 0; b < 4; b++) if (be[b]) word[8*b +: 8] = wdata[8*b +: 8];
        model_mem[idx] = word;
        if (be != 4'b0000) begin ntr = 1; tdata = word; end
      end else begin
        rd = word;
      end
    end
  endtask

  task automatic model_clear();
    for (int i = 0; i < DEPTH; i++) model_mem[i] = 32'd0;
  endtask

  // One full transaction; called at a negedge with both DUTs in IDLE.
  task automatic do_req(input logic w, input logic [31:0] addr, input logic [31:0] wdata,
                        input logic [3:0] be, input logic [31:0] pc, input int hold);
    logic [31:0] exp_rd, exp_td;
    logic        exp_err;
    int          exp_ntr;
    int          edges, a_lat, b_lat, a_ntr, b_ntr;
    logic [31:0] a_tpc, a_taddr, a_tdata, b_tdata;
    model_access(w, addr, wdata, be, exp_rd, exp_err, exp_ntr, exp_td);
    req_valid = 1'b1; req_write = w; req_addr = addr; req_wdata = wdata; req_be = be; req_pc = pc;
    check("a_ready_idle", {31'd0, a_req_ready}, 32'd1);
    check("b_ready_idle", {31'd0, b_req_ready}, 32'd1);
    @(posedge clk); #1;
    check("a_ready_busy", {31'd0, a_req_ready}, 32'd0);
    check("b_ready_busy", {31'd0, b_req_ready}, 32'd0);
    // Garbage on the request bus while busy must be ignored.
    req_write = 1'($urandom); req_addr = $urandom; req_wdata = $urandom;
    req_be = 4'($urandom); req_pc = $urandom;
    edges = 0; a_lat = -1; b_lat = -1; a_ntr = 0; b_ntr = 0;
    a_tpc = '0; a_taddr = '0; a_tdata = '0; b_tdata = '0;
    while (a_lat < 0 && edges < 20) begin
      @(negedge clk);
      if (b_lat < 0 && b_resp_valid) b_lat = edges;
      if (a_resp_valid) a_lat = edges;
      if (a_trace_valid) begin
        a_ntr++; a_tpc = a_trace_pc; a_taddr = a_trace_addr; a_tdata = a_trace_data;
        $display("@%08h: *%08h <= %08h", a_trace_pc, a_trace_addr, a_trace_data);
      end
      if (b_trace_valid) begin b_ntr++; b_tdata = b_trace_data; end
      if (a_lat < 0) begin @(posedge clk); edges++; end
    end
    check("a_latency", 32'(a_lat), 32'd2);
    check("b_latency", 32'(b_lat), 32'd1);
    check("a_trace_cnt", 32'(a_ntr), 32'(exp_ntr));
    check("b_trace_cnt", 32'(b_ntr), 32'(exp_ntr));
    if (exp_ntr != 0) begin
      check("a_trace_pc", a_tpc, pc);
      check("a_trace_addr", a_taddr, addr & 32'hFFFF_FFFC);
      check("a_trace_data", a_tdata, exp_td);
      check("b_trace_data", b_tdata, exp_td);
    end
    check("a_rdata", a_resp_rdata, exp_rd);
    check("a_err", {31'd0, a_resp_err}, {31'd0, exp_err});
    check("b_rdata", b_resp_rdata, exp_rd);
    check("b_err", {31'd0, b_resp_err}, {31'd0, exp_err});
    for (int i = 0; i < hold; i++) begin
      @(posedge clk); @(negedge clk);
      check("a_hold_valid", {31'd0, a_resp_valid}, 32'd1);
      check("a_hold_rdata", a_resp_rdata, exp_rd);
      check("a_hold_err", {31'd0, a_resp_err}, {31'd0, exp_err});
      check("a_hold_ready", {31'd0, a_req_ready}, 32'd0);
    end
    resp_ready = 1'b1;
    @(posedge clk); #1;
    resp_ready = 1'b0;
    // req_valid was still high at that edge: back in IDLE, nothing accepted.
    check("a_back_idle", {30'd0, a_req_ready, a_resp_valid}, 32'd2);
    check("b_back_idle", {30'd0, b_req_ready, b_resp_valid}, 32'd2);
    req_valid = 1'b0;
    $display("txn w=%0d addr=%08h wdata=%08h be=%h -> rdata=%08h err=%0d", w, addr, wdata, be,
             a_resp_rdata, a_resp_err);
    @(negedge clk);
  endtask

  // Store accepted, then reset while in BUSY.
  task automatic do_abort(input logic [31:0] addr, input logic [31:0] wdata);
    req_valid = 1'b1; req_write = 1'b1; req_addr = addr; req_wdata = wdata;
    req_be = 4'hF; req_pc = 32'h0000_4000;
    @(posedge clk); #1;
    req_valid = 1'b0;
    @(negedge clk);
    reset = 1'b1; #1;
    check("a_abort_trace", {31'd0, a_trace_valid}, 32'd0);
    check("b_abort_trace", {31'd0, b_trace_valid}, 32'd0);
    @(posedge clk); #1;
    model_clear();
    check("a_abort_state", {a_resp_rdata[29:0], a_req_ready, a_resp_valid}, 32'd2);
    check("b_abort_state", {b_resp_rdata[29:0], b_req_ready, b_resp_valid}, 32'd2);
    @(negedge clk);
    reset = 1'b0;
    $display("txn abort store addr=%08h", addr);
  endtask

  initial begin
    logic        w;
    logic [31:0] addr;
    model_clear();
    reset = 1'b1; req_valid = 1'b0; req_write = 1'b0; req_addr = '0;
    req_wdata = '0; req_be = '0; req_pc = '0; resp_ready = 1'b0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    check("a_rst_ready", {31'd0, a_req_ready}, 32'd1);
    check("a_rst_valid", {31'd0, a_resp_valid}, 32'd0);
    check("a_rst_rdata", a_resp_rdata, 32'd0);
    check("a_rst_err", {31'd0, a_resp_err}, 32'd0);
    check("b_rst_valid", {31'd0, b_resp_valid}, 32'd0);
    reset = 1'b0;

    // Directed: first request right after reset release.
    do_req(1'b1, 32'h0000_0004, 32'hDEAD_BEEF, 4'hF, 32'h0000_3000, 0);
    do_req(1'b0, 32'h0000_0004, 32'h0, 4'h0, 32'h0, 0);
    do_req(1'b0, 32'h0000_0006, 32'h0, 4'h0, 32'h0, 1);
    do_req(1'b1, 32'h0000_0004, 32'h0000_00AB, 4'b0001, 32'h0000_3004, 0);
    do_req(1'b0, 32'h0000_0004, 32'h0, 4'h0, 32'h0, 0);
    do_req(1'b1, 32'h0000_0004, 32'h1234_5678, 4'b0000, 32'h0000_3008, 0);
    do_req(1'b0, 32'h0000_0004, 32'h0, 4'h0, 32'h0, 0);
    do_req(1'b0, 32'h0000_1000, 32'h0, 4'h0, 32'h0, 0);
    do_req(1'b1, 32'h0000_1000, 32'hCAFE_F00D, 4'hF, 32'h0000_300C, 0);
    do_req(1'b0, 32'h0000_0000, 32'h0, 4'h0, 32'h0, 0);
    do_req(1'b0, 32'h0000_0FFC, 32'h0, 4'h0, 32'h0, 0);
    do_req(1'b1, 32'h0000_0FFC, 32'h5555_AAAA, 4'b1100, 32'h0000_3010, 0);
    do_req(1'b0, 32'h0000_0FFC, 32'h0, 4'h0, 32'h0, 0);
    do_req(1'b0, 32'h0000_0004, 32'h0, 4'h0, 32'h0, 5);

    // Directed: reset during BUSY of a store to addr 8.
    do_req(1'b1, 32'h0000_0008, 32'h0BAD_0BAD, 4'hF, 32'h0000_3014, 0);
    do_abort(32'h0000_0008, 32'h1111_2222);
    do_req(1'b0, 32'h0000_0008, 32'h0, 4'h0, 32'h0, 0);
    do_req(1'b0, 32'h0000_0004, 32'h0, 4'h0, 32'h0, 0);

    // Randomized traffic against the model.
    for (int t = 0; t < 40; t++) begin
      w = 1'($urandom);
      if ($urandom_range(0, 9) == 0) addr = $urandom | 32'h0000_1000;
      else addr = 32'($urandom_range(0, 63) * 4 + $urandom_range(0, 3));
      do_req(w, addr, $urandom, 4'($urandom), $urandom, int'($urandom_range(0, 3)));
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
